if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID register. Owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and presents the fetched instruction with its PC on `ir_IF`/`pc_IF`. Honours the ID-stage hazard stall and the EX-stage branch/jump redirect. Emits `32'h0` (NOP) bubbles when no instruction is ready.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/pc_gen.sv | 16 +
 rtl/if_stage.sv | 62 ++++++
 tb/tb_if_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and fetch-state encoding for the pipeline front end.
package cpu_pkg;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: next-fetch-address register with sequential increment and redirect override.
module pc_gen import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc_q
);
    always_ff @(posedge clk)
        if (rst) pc_q <= RESET_PC;
        else if (redirect) pc_q <= target & ~32'h3;
        else if (advance) pc_q <= pc_q + PC_STEP;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with single outstanding memory request, stall hold and redirect flush.
module if_stage import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_rready,
    output logic [31:0] ir_IF,
    output logic [31:0] pc_IF,
    output logic        if_valid
);
    fetch_state_e state, state_d;
    logic [31:0] pc_q, req_pc, out_ir, out_pc;
    logic out_valid, consume, space, resp_acc, req_acc;
    assign consume  = out_valid & ~stall;
    assign space    = ~out_valid | consume;
    // A redirect drains any pending response so the memory never stalls on a dead fetch.
    assign imem_rready = ~rst & (state != IDLE) & (redirect | state == DROP | space);
    assign resp_acc = imem_rvalid & imem_rready;
    assign imem_req = ~rst & ~redirect & (state == IDLE | resp_acc);
    assign req_acc  = imem_req & imem_ready;
    assign imem_addr = pc_q;
    assign if_valid = out_valid;
    assign ir_IF    = out_valid ? out_ir : NOP;
    assign pc_IF    = out_valid ? out_pc : NOP;
    pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk(clk), .rst(rst), .redirect(redirect), .target(redirect_pc),
        .advance(req_acc), .pc_q(pc_q)
    );
    always_comb begin
        state_d = state;
        if (redirect) state_d = (state != IDLE && !resp_acc) ? DROP : IDLE;
        else if (req_acc) state_d = WAIT;
        else if (resp_acc) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_pc    <= 32'h0;
            out_valid <= 1'b0;
            out_ir    <= NOP;
            out_pc    <= 32'h0;
        end else begin
            state <= state_d;
            if (req_acc) req_pc <= pc_q;
            if (redirect) out_valid <= 1'b0;
            else if (resp_acc && state == WAIT) begin
                out_valid <= 1'b1;
                out_ir    <= imem_rdata;
                out_pc    <= req_pc;
            end else if (consume) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch streaming, stall, redirect, wrap and reset behaviour.
module tb_if_stage;
    logic        clk = 0, rst = 1, stall = 0, redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic        imem_req, imem_ready, imem_rvalid, imem_rready, if_valid;
    logic [31:0] imem_addr, imem_rdata, ir_IF, pc_IF;
    logic        req2, rready2, valid2, rv2 = 0;
    logic [31:0] addr2, ir2, pc2, ad2 = 0;
    logic        pend = 0, mem_ready = 1;
    logic [31:0] m_addr = 0;
    int          cnt = 0, lat = 0;
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rready(imem_rready),
        .ir_IF(ir_IF), .pc_IF(pc_IF), .if_valid(if_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
        .imem_rvalid(rv2), .imem_rdata(ad2 ^ 32'hA5A5_0000), .imem_rready(rready2),
        .ir_IF(ir2), .pc_IF(pc2), .if_valid(valid2)
    );

    // Memory: holds one request, answers after lat extra cycles, holds data until taken.
    assign imem_ready  = mem_ready;
    assign imem_rvalid = pend && cnt == 0;
    assign imem_rdata  = m_addr ^ 32'hA5A5_0000;
    always @(posedge clk) begin
        if (rst) pend <= 0;
        else begin
            if (imem_rvalid && imem_rready) pend <= 0;
            else if (pend && cnt != 0) cnt <= cnt - 1;
            if (imem_req && imem_ready) begin
                pend <= 1; m_addr <= imem_addr; cnt <= lat;
            end
        end
    end

    always @(posedge clk) begin
        rv2 <= rst ? 1'b0 : (req2 ? 1'b1 : rv2 & ~rready2);
        if (req2) ad2 <= addr2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_valid", {31'b0, if_valid}, 0);
        chk("rst_ir", ir_IF, 0);
        chk("rst_pc", pc_IF, 0);
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_rready", {31'b0, imem_rready}, 0);
        rst = 0; #1;
        chk("first_req", {31'b0, imem_req}, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
        cyc();
        chk("addr4", imem_addr, 32'h4);
        chk("no_out_yet", {31'b0, if_valid}, 0);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        cyc();
        chk("pc0", pc_IF, 32'h0);
        chk("ir0", ir_IF, 32'hA5A5_0000);
        chk("valid0", {31'b0, if_valid}, 1);
        chk("wrap_addr2", addr2, 32'h0);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        cyc();
        chk("pc4", pc_IF, 32'h4);
        chk("ir4", ir_IF, 32'hA5A5_0004);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        cyc();
        chk("pc8", pc_IF, 32'h8);
        chk("wrap_pc2", pc2, 32'h0);
        chk("wrap_valid2", {31'b0, valid2}, 1);
        // stall three cycles with a response waiting
        stall = 1; #1;
        chk("stall_rvalid", {31'b0, imem_rvalid}, 1);
        chk("stall_rready", {31'b0, imem_rready}, 0);
        chk("stall_req", {31'b0, imem_req}, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc_IF, 32'h8);
            chk("stall_ir", ir_IF, 32'hA5A5_0008);
        end
        stall = 0;
        cyc();
        chk("resume_pcC", pc_IF, 32'hC);
        cyc();
        chk("resume_pc10", pc_IF, 32'h10);
        // redirect while a slow response is pending
        lat = 2;
        cyc();
        chk("pc14", pc_IF, 32'h14);
        redirect = 1; redirect_pc = 32'h0000_0103; #1;
        chk("redir_noreq", {31'b0, imem_req}, 0);
        cyc();
        redirect = 0;
        chk("redir_valid", {31'b0, if_valid}, 0);
        chk("redir_ir", ir_IF, 0);
        chk("drop_noreq", {31'b0, imem_req}, 0);
        cyc();
        chk("drop_rvalid", {31'b0, imem_rvalid}, 1);
        chk("drop_rready", {31'b0, imem_rready}, 1);
        chk("drop_req", {31'b0, imem_req}, 1);
        chk("drop_addr", imem_addr, 32'h100);
        lat = 0;
        cyc();
        chk("dropped_valid", {31'b0, if_valid}, 0);
        cyc();
        chk("target_pc", pc_IF, 32'h100);
        chk("target_ir", ir_IF, 32'hA5A5_0100);
        // redirect plus stall with a response arriving that cycle
        stall = 1; redirect = 1; redirect_pc = 32'h200; #1;
        chk("rs_rvalid", {31'b0, imem_rvalid}, 1);
        chk("rs_rready", {31'b0, imem_rready}, 1);
        cyc();
        stall = 0; redirect = 0; #1;
        chk("rs_flush", {31'b0, if_valid}, 0);
        chk("rs_addr", imem_addr, 32'h200);
        chk("rs_req", {31'b0, imem_req}, 1);
        cyc();
        chk("rs_wait", {31'b0, if_valid}, 0);
        cyc();
        chk("rs_pc", pc_IF, 32'h200);
        chk("rs_ir", ir_IF, 32'hA5A5_0200);
        // memory not ready, then reset in the middle of a pending fetch
        mem_ready = 0;
        cyc();
        chk("pc204", pc_IF, 32'h204);
        for (int i = 0; i < 4; i++) begin
            chk("hold_req", {31'b0, imem_req}, 1);
            chk("hold_addr", imem_addr, 32'h208);
            cyc();
        end
        mem_ready = 1; lat = 3;
        cyc();
        chk("wait_noreq", {31'b0, imem_req}, 0);
        rst = 1;
        cyc();
        chk("mid_rst_valid", {31'b0, if_valid}, 0);
        chk("mid_rst_ir", ir_IF, 0);
        chk("mid_rst_pc", pc_IF, 0);
        chk("mid_rst_req", {31'b0, imem_req}, 0);
        chk("mid_rst_rready", {31'b0, imem_rready}, 0);
        rst = 0; lat = 0; #1;
        chk("restart_req", {31'b0, imem_req}, 1);
        chk("restart_addr", imem_addr, 32'h0);
        cyc(); cyc();
        chk("restart_pc", pc_IF, 32'h0);
        chk("restart_ir", ir_IF, 32'hA5A5_0000);
        chk("restart_valid", {31'b0, if_valid}, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
